// File: rtl/sat_pkg.sv
// Shared types and default widths for the saturation episode reporter.
// Used by sat_event_reporter and its dwell counter.
package sat_pkg;

    localparam int DEF_N  = 4;
    localparam int DEF_DW = 8;
    localparam int DEF_EW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAT  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/sat_dwell_cntr.sv
// W-bit saturating up-counter: load1 restarts the count at 1, inc adds one
// and sticks at all-ones instead of wrapping.
module sat_dwell_cntr
    import sat_pkg::*;
#(
    parameter int W = DEF_DW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] value
);

    // NOTE: sequential state is always updated with <= so every flop samples
    // the pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load1) begin
            value <= W'(1);
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/sat_event_reporter.sv
// Measures each saturation episode of an N-bit counter and reports it on a
// valid/ready stream. Define SAT_EVT_LOST_CNT_EN to add the lost_cnt output.
module sat_event_reporter
    import sat_pkg::*;
#(
    parameter int          N         = DEF_N,
    parameter int unsigned MAX_COUNT = 2**N - 1,
    parameter int          DW        = DEF_DW,
    parameter int          EW        = DEF_EW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  cnt_in,
    output logic          sat_out,
    output logic          busy,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [DW-1:0] evt_dwell,
    output logic [EW-1:0] evt_epoch,
    output logic          evt_lost
`ifdef SAT_EVT_LOST_CNT_EN
    ,
    output logic [EW-1:0] lost_cnt
`endif
);

    state_t        state, state_next;
    logic [N-1:0]  cnt_q;
    logic          sat_now, sat_prev, sat_rise;
    logic [DW-1:0] dwell;
    logic [EW-1:0] epoch;
    logic          dwell_load1, dwell_inc, capture, accept, drop;

    assign sat_now  = (cnt_q == N'(MAX_COUNT));
    assign sat_rise = sat_now && !sat_prev;
    assign sat_out  = sat_now;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        dwell_load1 = 1'b0;
        dwell_inc   = 1'b0;
        capture     = 1'b0;
        accept      = 1'b0;
        drop        = 1'b0;
        case (state)
            IDLE: begin
                if (sat_rise) begin
                    dwell_load1 = 1'b1;
                    state_next  = SAT;
                end
            end
            SAT: begin
                if (sat_now) begin
                    dwell_inc = 1'b1;
                end else begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (evt_valid && evt_ready) begin
                    accept = 1'b1;
                    // A new episode starting on the handshake cycle is kept.
                    if (sat_rise) begin
                        dwell_load1 = 1'b1;
                        state_next  = SAT;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (sat_rise) begin
                    drop = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    sat_dwell_cntr #(.W(DW)) u_dwell (
        .clk   (clk),
        .reset (reset),
        .load1 (dwell_load1),
        .inc   (dwell_inc),
        .value (dwell)
    );

`ifdef SAT_EVT_LOST_CNT_EN
    sat_dwell_cntr #(.W(EW)) u_lost (
        .clk   (clk),
        .reset (reset),
        .load1 (1'b0),
        .inc   (drop),
        .value (lost_cnt)
    );
`endif

    // Input stage and report register; record fields hold between reports.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            sat_prev  <= 1'b0;
            evt_valid <= 1'b0;
            evt_dwell <= '0;
            evt_epoch <= '0;
            epoch     <= '0;
            evt_lost  <= 1'b0;
        end else begin
            cnt_q    <= cnt_in;
            sat_prev <= sat_now;
            if (capture) begin
                evt_valid <= 1'b1;
                evt_dwell <= dwell;
                evt_epoch <= epoch;
                epoch     <= epoch + 1'b1;
            end else if (accept) begin
                evt_valid <= 1'b0;
            end
            if (drop) evt_lost <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sat_event_reporter.sv
// Directed bench for sat_event_reporter; the lost_cnt checks are compiled only
// when SAT_EVT_LOST_CNT_EN is defined.
module tb_sat_event_reporter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cnt_in;
    logic       sat_out, busy, evt_valid, evt_ready, evt_lost;
    logic [7:0] evt_dwell;
    logic [3:0] evt_epoch;
`ifdef SAT_EVT_LOST_CNT_EN
    logic [3:0] lost_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_rec;
    int exp_epoch;

    sat_event_reporter dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_in    (cnt_in),
        .sat_out   (sat_out),
        .busy      (busy),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_dwell (evt_dwell),
        .evt_epoch (evt_epoch),
        .evt_lost  (evt_lost)
`ifdef SAT_EVT_LOST_CNT_EN
        ,
        .lost_cnt  (lost_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs are driven before the call; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic episode(input int len, input int gap);
        cnt_in = 4'd15;
        repeat (len) tick();
        cnt_in = 4'd0;
        repeat (gap) tick();
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (!evt_valid && n < bound) begin
            tick();
            n++;
        end
        check("valid_timeout", 32'(evt_valid), 1);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        cnt_in = 4'd0;
        tick();
        tick();
        reset  = 1'b0;
    endtask

    task automatic tick_mon();
        tick();
        if (evt_valid) begin
            check("b2b_epoch", 32'(evt_epoch), 32'(exp_epoch));
            check("b2b_dwell", 32'(evt_dwell), 3);
            n_rec++;
            exp_epoch = (exp_epoch + 1) % 16;
        end
    endtask

    initial begin
        evt_ready = 1'b0;
        do_reset();
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_sat",   32'(sat_out), 0);
        check("rst_lost",  32'(evt_lost), 0);
        check("rst_dwell", 32'(evt_dwell), 0);
        check("rst_epoch", 32'(evt_epoch), 0);

        // Ramp, then 5 saturated cycles: one record, dwell 5, epoch 0.
        evt_ready = 1'b1;
        for (int v = 0; v < 15; v++) begin
            cnt_in = 4'(v);
            tick();
        end
        check("ramp_sat", 32'(sat_out), 0);
        cnt_in = 4'd15;
        tick();
        check("first_sat", 32'(sat_out), 1);
        check("first_busy", 32'(busy), 0);
        repeat (4) tick();
        check("sat_busy", 32'(busy), 1);
        check("sat_valid", 32'(evt_valid), 0);
        cnt_in = 4'd0;
        tick();
        check("lat_t1_valid", 32'(evt_valid), 0);
        tick();
        check("lat_t2_valid", 32'(evt_valid), 1);
        check("t1_dwell", 32'(evt_dwell), 5);
        check("t1_epoch", 32'(evt_epoch), 0);
        tick();
        check("t1_valid_1cyc", 32'(evt_valid), 0);
        check("t1_idle", 32'(busy), 0);

        // 300-cycle episode clamps dwell at 255.
        cnt_in = 4'd15;
        repeat (300) tick();
        cnt_in = 4'd0;
        wait_valid(8);
        check("clamp_dwell", 32'(evt_dwell), 255);
        check("clamp_epoch", 32'(evt_epoch), 1);
        tick();
        check("clamp_accept", 32'(evt_valid), 0);

        // Reset in the middle of an episode (dwell = 4) discards it.
        cnt_in = 4'd15;
        repeat (5) tick();
        check("mid_busy", 32'(busy), 1);
        reset  = 1'b1;
        cnt_in = 4'd0;
        tick();
        reset  = 1'b0;
        check("midrst_valid", 32'(evt_valid), 0);
        check("midrst_busy",  32'(busy), 0);
        check("midrst_sat",   32'(sat_out), 0);

        // 17 back-to-back episodes with ready high: epochs 0..15, 0.
        n_rec     = 0;
        exp_epoch = 0;
        for (int ep = 0; ep < 17; ep++) begin
            for (int k = 0; k < 4; k++) begin
                cnt_in = (k < 3) ? 4'd15 : 4'd0;
                tick_mon();
            end
        end
        repeat (4) tick_mon();
        check("b2b_count", 32'(n_rec), 17);
        check("b2b_lost",  32'(evt_lost), 0);

        // Ready held low: first record held, later episodes dropped.
        do_reset();
        evt_ready = 1'b0;
        episode(3, 2);
        check("hold_valid", 32'(evt_valid), 1);
        check("hold_dwell", 32'(evt_dwell), 3);
        check("hold_epoch", 32'(evt_epoch), 0);
        check("hold_lost0", 32'(evt_lost), 0);
        episode(3, 2);
        check("drop_lost",  32'(evt_lost), 1);
        check("drop_valid", 32'(evt_valid), 1);
        check("drop_dwell", 32'(evt_dwell), 3);
        check("drop_epoch", 32'(evt_epoch), 0);
`ifdef SAT_EVT_LOST_CNT_EN
        check("lost_cnt_1", 32'(lost_cnt), 1);
`endif
        repeat (15) episode(3, 2);
        check("stable_valid", 32'(evt_valid), 1);
        check("stable_dwell", 32'(evt_dwell), 3);
        check("stable_epoch", 32'(evt_epoch), 0);
`ifdef SAT_EVT_LOST_CNT_EN
        check("lost_cnt_16", 32'(lost_cnt), 15);
`endif
        evt_ready = 1'b1;
        tick();
        check("release_valid", 32'(evt_valid), 0);
        check("release_busy",  32'(busy), 0);
        episode(4, 0);
        wait_valid(8);
        check("after_dwell", 32'(evt_dwell), 4);
        check("after_epoch", 32'(evt_epoch), 1);
        check("after_lost",  32'(evt_lost), 1);
        tick();

`ifdef SAT_EVT_LOST_CNT_EN
        // 20 dropped episodes saturate lost_cnt at 15.
        do_reset();
        check("lc_rst", 32'(lost_cnt), 0);
        check("lc_rst_lost", 32'(evt_lost), 0);
        evt_ready = 1'b0;
        repeat (21) episode(3, 2);
        check("lc_sat", 32'(lost_cnt), 15);
        check("lc_lost", 32'(evt_lost), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sat_event_reporter.md
Name: sat_event_reporter

Overview:
- Downstream monitor for the N-bit saturating counter. It watches the counter value, measures how many cycles each saturation episode lasts, and reports each finished episode as a record on a valid/ready output stream.
- An episode ends when the counter leaves MAX_COUNT, which normally happens because the counter was reset.
- Sits between the counter and the status/interrupt logic.

Parameters:
- N, 4, width of the monitored counter value.
- MAX_COUNT, 2**N-1, saturation value; must match the counter's value.
- DW, 8, width of the dwell-length field.
- EW, 4, width of the episode-index field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cnt_in  input  N  counter value, sampled every cycle.
- sat_out  output  1  registered flag, cnt_in==MAX_COUNT, delayed 1 cycle.
- busy  output  1  high whenever FSM state != IDLE.
- evt_valid  output  1  report record available.
- evt_ready  input  1  consumer accepts the record.
- evt_dwell  output  DW  number of cycles the episode was saturated (saturating).
- evt_epoch  output  EW  episode index; wraps modulo 2**EW.
- evt_lost  output  1  sticky: at least one episode was dropped.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high. All outputs and registers are 0 after reset, and the FSM is in IDLE.
- Input stage: cnt_q <= cnt_in every cycle. sat_now = (cnt_q==MAX_COUNT). sat_prev <= sat_now. sat_out = sat_now.
- State IDLE:
  - On a rising edge (sat_now && !sat_prev): set dwell <= 1, go to SAT.
  - Otherwise stay in IDLE.
  - If sat_now is already high on entering IDLE, that episode is ignored until sat_now drops and rises again.
- State SAT:
  - While sat_now is high: dwell <= dwell+1, clamped at 2**DW-1 (no wrap).
  - When sat_now is low: evt_dwell <= dwell, evt_epoch <= epoch, evt_valid <= 1, epoch <= epoch+1 (wraps), go to HOLD.
- State HOLD:
  - evt_valid stays high and evt_dwell/evt_epoch are stable until evt_valid && evt_ready.
  - On the handshake cycle, evt_valid <= 0 on the next edge.
  - If the handshake and a rising edge occur in the same cycle: dwell <= 1, go to SAT; nothing is lost.
  - Otherwise after the handshake, go to IDLE.
- Episode loss: a rising edge of sat_now seen in HOLD with no handshake that cycle drops the episode and sets evt_lost <= 1. evt_lost is cleared only by reset.
- Latency: cnt_in leaving MAX_COUNT at edge t gives evt_valid high after edge t+2. Minimum episode length is dwell=1.
- evt_ready is ignored while evt_valid is low. The evt_* data fields are don't-care while evt_valid is low, but are held at their last value.
- Reset mid-episode or mid-HOLD: the record is discarded with no handshake; epoch returns to 0.

Optional Feature:
- Macro SAT_EVT_LOST_CNT_EN.
- Defined: adds output lost_cnt [EW-1:0], which counts dropped episodes. It increments on every event that sets evt_lost, saturates at 2**EW-1, and resets to 0.
- Not defined: the lost_cnt port and its logic do not exist; only the sticky evt_lost flag is present.

Decomposition:
- Package sat_pkg holds:
  - State enum: IDLE=2'd0, SAT=2'd1, HOLD=2'd2.
  - Default widths: N, DW, EW.
- One sub-module, sat_dwell_cntr: a DW-bit saturating counter with inputs load1 and inc and output value. It is used for dwell, and reused for lost_cnt when SAT_EVT_LOST_CNT_EN is defined.
- The FSM, input stage and output register stay in the top module.

Test Plan:
- After reset, drive cnt_in 0..15 with cnt_in=15 for 5 cycles, then 0; evt_ready=1 -> one record with evt_dwell=5, evt_epoch=0; evt_valid high exactly 1 cycle, asserted 2 cycles after cnt_in leaves 15.
- cnt_in=15 for 300 cycles with DW=8 -> evt_dwell=255 (clamped, no wrap).
- evt_ready=0, 17 episodes of 3 cycles each -> first record held stable with evt_dwell=3, evt_epoch=0; evt_lost=1 after the second episode's rise. Release ready -> the next record reported is from a later episode.
- evt_ready=1, 17 back-to-back episodes -> evt_epoch runs 0..15 then 0; evt_lost stays 0.
- Assert reset mid-SAT with dwell=4 -> next cycle evt_valid=0, busy=0, epoch=0; the next episode reports evt_epoch=0.
- Repeat the lost-episode scenario with SAT_EVT_LOST_CNT_EN defined and 20 dropped episodes -> lost_cnt=15 (saturated).
